// File: rtl/pw_input_cond.sv
// Password input conditioner: synchronizes the raw switches and enter button, debounces
// enter presses and releases, and emits one registered accept strobe per press.
module pw_input_cond #(
    parameter int unsigned CHAR_W    = 7,
    parameter int unsigned DB_CYCLES = 16000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              enter_in,
    output logic [CHAR_W-1:0] char_out,
    output logic              enter_pulse,
    output logic              busy,
    output logic [7:0]        glitch_cnt
);

    localparam int unsigned      CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [7:0]       GLITCH_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } state_e;

    logic [CHAR_W-1:0] char_meta_q, char_sync_q;
    logic              enter_meta_q, enter_sync_q;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CHAR_W-1:0] char_ref_q, char_ref_d;
    logic [CHAR_W-1:0] char_out_q, char_out_d;
    logic              pulse_q, pulse_d;
    logic              busy_q, busy_d;
    logic [7:0]        glitch_q, glitch_d;

    // Two-flop synchronizers; only the second stage is used downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            char_meta_q  <= '0;
            char_sync_q  <= '0;
            enter_meta_q <= 1'b0;
            enter_sync_q <= 1'b0;
        end else begin
            char_meta_q  <= char_in;
            char_sync_q  <= char_meta_q;
            enter_meta_q <= enter_in;
            enter_sync_q <= enter_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            char_ref_q <= '0;
            char_out_q <= '0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            glitch_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            char_ref_q <= char_ref_d;
            char_out_q <= char_out_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            glitch_q   <= glitch_d;
        end
    end

    // Enter-low abort is tested before the character-change restart.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        char_ref_d = char_ref_q;
        char_out_d = char_out_q;
        pulse_d    = 1'b0;
        glitch_d   = glitch_q;

        case (state_q)
            ST_IDLE: begin
                if (enter_sync_q) begin
                    state_d    = ST_DB_PRESS;
                    cnt_d      = '0;
                    char_ref_d = char_sync_q;
                end
            end
            ST_DB_PRESS: begin
                if (!enter_sync_q) begin
                    state_d = ST_IDLE;
                    if (glitch_q != GLITCH_MAX) begin
                        glitch_d = glitch_q + 8'd1;
                    end
                end else if (char_sync_q != char_ref_q) begin
                    char_ref_d = char_sync_q;
                    cnt_d      = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_HELD;
                    char_out_d = char_ref_q;
                    pulse_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!enter_sync_q) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_DB_RELEASE: begin
                if (enter_sync_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign char_out    = char_out_q;
    assign enter_pulse = pulse_q;
    assign busy        = busy_q;
    assign glitch_cnt  = glitch_q;

endmodule

// File: tb/tb_pw_input_cond.sv
// Scoreboard bench for pw_input_cond: stimulus pushes expected accept strobes
// (edge number and character), a negedge monitor pops and compares them.
module tb_pw_input_cond;

    localparam int unsigned CHAR_W    = 7;
    localparam int unsigned DB_CYCLES = 4;

    logic              clk;
    logic              reset_n;
    logic [CHAR_W-1:0] char_in;
    logic              enter_in;
    logic [CHAR_W-1:0] char_out;
    logic              enter_pulse;
    logic              busy;
    logic [7:0]        glitch_cnt;

    typedef struct {
        int unsigned       cyc;
        logic [CHAR_W-1:0] ch;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned edge_cnt;
    int          n_checks;
    int          n_fail;

    pw_input_cond #(
        .CHAR_W   (CHAR_W),
        .DB_CYCLES(DB_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_in    (char_in),
        .enter_in   (enter_in),
        .char_out   (char_out),
        .enter_pulse(enter_pulse),
        .busy       (busy),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: every observed strobe must match the oldest expected accept.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1 && enter_pulse === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse with char_out=0x%0h, expected none (edge %0d)",
                         char_out, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_edge", edge_cnt, e.cyc);
                chk("pulse_char", 32'(char_out), 32'(e.ch));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press accepted DB_CYCLES+3 edges after the first edge that samples enter high.
    task automatic expect_accept(input int unsigned extra, input logic [CHAR_W-1:0] ch);
        exp_t e;
        e.cyc = edge_cnt + DB_CYCLES + 3 + extra;
        e.ch  = ch;
        exp_q.push_back(e);
    endtask

    task automatic glitch(input int hi, input int lo);
        enter_in = 1'b1;
        cycles(hi);
        enter_in = 1'b0;
        cycles(lo);
    endtask

    initial begin
        int waited;
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        char_in  = '0;
        enter_in = 1'b0;
        cycles(3);
        chk("rst_char_out", 32'(char_out), 32'h0);
        chk("rst_pulse", 32'(enter_pulse), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_glitch", 32'(glitch_cnt), 32'h0);
        reset_n = 1'b1;
        cycles(3);

        // Clean press held 20 cycles, then release debounce.
        char_in  = 7'h2A;
        enter_in = 1'b1;
        expect_accept(0, 7'h2A);
        cycles(3);
        chk("press_busy", 32'(busy), 32'h1);
        cycles(17);
        chk("hold_char_out", 32'(char_out), 32'h2A);
        enter_in = 1'b0;
        cycles(6);
        chk("release_busy_hi", 32'(busy), 32'h1);
        cycles(1);
        chk("release_busy_lo", 32'(busy), 32'h0);
        cycles(3);

        // Short glitch: aborted press, no strobe.
        char_in = 7'h05;
        glitch(2, 8);
        chk("glitch_cnt_1", 32'(glitch_cnt), 32'h1);
        chk("glitch_char_out", 32'(char_out), 32'h2A);
        chk("glitch_busy", 32'(busy), 32'h0);

        // Character change mid-debounce restarts the count.
        char_in  = 7'h11;
        enter_in = 1'b1;
        expect_accept(3, 7'h12);
        cycles(3);
        char_in = 7'h12;
        cycles(12);
        chk("restart_char_out", 32'(char_out), 32'h12);

        // Bouncy release after accept: no second strobe, back to idle.
        enter_in = 1'b0;
        cycles(2);
        enter_in = 1'b1;
        cycles(2);
        enter_in = 1'b0;
        cycles(10);
        chk("bounce_busy", 32'(busy), 32'h0);
        chk("bounce_char_out", 32'(char_out), 32'h12);

        // Reset mid-press abandons it; press held across release is new.
        char_in  = 7'h33;
        enter_in = 1'b1;
        cycles(4);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_char_out", 32'(char_out), 32'h0);
        chk("midrst_pulse", 32'(enter_pulse), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_glitch", 32'(glitch_cnt), 32'h0);
        cycles(3);
        reset_n = 1'b1;
        expect_accept(0, 7'h33);
        cycles(10);
        chk("postrst_char_out", 32'(char_out), 32'h33);
        enter_in = 1'b0;
        cycles(10);

        // Saturating glitch counter, then a normal press still works.
        char_in = 7'h01;
        for (int i = 0; i < 300; i++) begin
            glitch(2, 5);
        end
        chk("glitch_sat", 32'(glitch_cnt), 32'hFF);
        chk("glitch_sat_char", 32'(char_out), 32'h33);
        char_in  = 7'h55;
        enter_in = 1'b1;
        expect_accept(0, 7'h55);
        cycles(10);
        enter_in = 1'b0;
        cycles(10);
        chk("final_char_out", 32'(char_out), 32'h55);
        chk("final_glitch", 32'(glitch_cnt), 32'hFF);
        chk("final_busy", 32'(busy), 32'h0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            cycles(1);
            waited++;
        end
        chk("missing_pulses", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pw_input_cond.md
PW_INPUT_COND -- requirements
Module: pw_input_cond

Interface
REQ-001 Parameter CHAR_W, default 7, width of the password character bus.
REQ-002 Parameter DB_CYCLES, default 16000 (benches use 4), number of consecutive stable cycles required to accept a press or release; legal range >= 2.
REQ-003 clk  input  1  FSM clock; all logic on rising edge; single clock domain.
REQ-004 reset_n  input  1  asynchronous, active-low reset; asserts immediately, released synchronously by upstream lock logic.
REQ-005 char_in  input  CHAR_W  raw password switches; asynchronous to clk.
REQ-006 enter_in  input  1  raw enter button, active-high, asynchronous and bouncy.
REQ-007 char_out  output  CHAR_W  last accepted character; registered; feeds the password FSM char input.
REQ-008 enter_pulse  output  1  single-cycle accept strobe; registered; feeds the password FSM enter input.
REQ-009 busy  output  1  high whenever FSM is not IDLE.
REQ-010 glitch_cnt  output  8  saturating count of aborted presses.

Function
REQ-011 char_in and enter_in SHALL each pass through a two-flop synchronizer; FSM uses only the second-flop outputs (char_sync, enter_sync).
REQ-012 FSM states SHALL be IDLE, DB_PRESS, HELD, DB_RELEASE; debounce counter width clog2(DB_CYCLES).
REQ-013 IDLE: enter_sync=1 -> DB_PRESS, cnt<=0, char_ref<=char_sync; else stay.
REQ-014 DB_PRESS: enter_sync=0 -> IDLE, glitch_cnt+1 (saturate at 255, no wrap).
REQ-015 DB_PRESS: enter_sync=1 and char_sync!=char_ref -> char_ref<=char_sync, cnt<=0, stay (char change restarts debounce).
REQ-016 DB_PRESS: enter_sync=1, char stable, cnt<DB_CYCLES-1 -> cnt+1.
REQ-017 DB_PRESS: enter_sync=1, char stable, cnt==DB_CYCLES-1 -> HELD, char_out<=char_ref, enter_pulse<=1 for exactly one cycle.
REQ-018 Enter-abort check (REQ-014) SHALL take priority over char-change check (REQ-015).
REQ-019 HELD: enter_sync=0 -> DB_RELEASE, cnt<=0; else stay; char_in changes ignored.
REQ-020 DB_RELEASE: enter_sync=1 -> cnt<=0, stay; enter_sync=0 and cnt==DB_CYCLES-1 -> IDLE; else cnt+1.
REQ-021 Exactly one enter_pulse per accepted press regardless of hold length or release bounce; no pulse generated outside the DB_PRESS->HELD transition.
REQ-022 Latency: enter_in and char_in stable from the edge that first samples enter_in=1 (edge 1) -> enter_pulse high after edge DB_CYCLES+3.
REQ-023 char_out SHALL change only on acceptance and hold its value otherwise.
REQ-024 Illegal state encodings SHALL return to IDLE on the next edge with no pulse.

Reset
REQ-025 reset_n=0 SHALL asynchronously clear synchronizers, state (IDLE), cnt, char_ref, char_out (0), enter_pulse (0), busy (0), glitch_cnt (0).
REQ-026 Reset mid-press SHALL abandon the press; no enter_pulse may be emitted for input held across reset release until enter is seen low then high again? No -- a press held across release SHALL be debounced afresh from IDLE as a new press.

Verification (DB_CYCLES=4)
REQ-027 Assert reset_n=0 mid-run -> all outputs 0 immediately, state IDLE.
REQ-028 char_in=0x2A, enter_in=1 held 20 cycles -> one enter_pulse after edge 7, char_out=0x2A, no further pulse, busy high until 4 stable-low cycles after release.
REQ-029 enter_in high 2 cycles then low -> no enter_pulse, glitch_cnt=1, char_out unchanged.
REQ-030 enter_in=1, char_in 0x11 then 0x12 at edge 4 -> pulse delayed by restart, char_out=0x12.
REQ-031 After accept, enter_in toggles low 2 / high 2 / low 10 -> no second pulse, return to IDLE.
REQ-032 300 short glitches -> glitch_cnt=255 (saturated); then clean press accepted normally.
